alu_share_arbiter: RTL and testbench

//  Shares the single 32-bit ALU between two requesters: req0 is the EX-stage datapath and req1 is the address/branch helper.

---
 rtl/alu_arb_pkg.sv | 29 ++
 rtl/rr_arb2.sv | 22 ++
 rtl/alu_share_arbiter.sv | 177 +++++++++++++++++
 tb/tb_alu_share_arbiter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arb_pkg.sv
// Shared definitions for the two-requester ALU sharing arbiter.
//  - Function codes of the operations the shared ALU implements.
//  - Encoding of the arbiter sequencing FSM.
//  - is_supported(): true for a function code the ALU implements.
package alu_arb_pkg;

    localparam int unsigned FUNCT_CODE_W = 6;

    localparam logic [FUNCT_CODE_W-1:0] FUNCT_ADDU = 6'b001001;
    localparam logic [FUNCT_CODE_W-1:0] FUNCT_SUBU = 6'b001010;
    localparam logic [FUNCT_CODE_W-1:0] FUNCT_AND  = 6'b010001;
    localparam logic [FUNCT_CODE_W-1:0] FUNCT_SLL  = 6'b100001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    function automatic logic is_supported(input logic [FUNCT_CODE_W-1:0] funct);
        logic ok;
        case (funct)
            FUNCT_ADDU, FUNCT_SUBU, FUNCT_AND, FUNCT_SLL: ok = 1'b1;
            default:                                     ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant logic, purely combinational.
// Ports:
//  req   in   2  request bits, bit N for requester N
//  prio  in   1  requester preferred when both request
//  gnt   out  2  one-hot grant (all zero when nobody requests)
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       prio,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = prio ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU between the EX-stage datapath (requester 0) and the
// address/branch helper (requester 1). One operation is in flight at a time:
// IDLE accepts a request, EXEC drives the ALU from registered operands and
// samples its outputs, RESP hands the captured result back to the owner.
// Ports:
//  clk, rst_n                    clock, async active-low reset
//  reqN_valid/ready              request handshake, N = 0,1
//  reqN_src1/src2/funct/shamt    request payload
//  rspN_valid/ready              response handshake, N = 0,1
//  rsp_result/zero/err           response payload, shared by both channels
//  alu_src1/src2/funct/shamt     operands to the shared ALU
//  alu_result/zero               outputs of the shared ALU
//  busy                          an operation is in flight
module alu_share_arbiter
    import alu_arb_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned FUNCT_W = 6,
    parameter int unsigned SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,

    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [DATA_W-1:0]  req0_src1,
    input  logic [DATA_W-1:0]  req0_src2,
    input  logic [FUNCT_W-1:0] req0_funct,
    input  logic [SHAMT_W-1:0] req0_shamt,

    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [DATA_W-1:0]  req1_src1,
    input  logic [DATA_W-1:0]  req1_src2,
    input  logic [FUNCT_W-1:0] req1_funct,
    input  logic [SHAMT_W-1:0] req1_shamt,

    output logic               rsp0_valid,
    input  logic               rsp0_ready,
    output logic               rsp1_valid,
    input  logic               rsp1_ready,
    output logic [DATA_W-1:0]  rsp_result,
    output logic               rsp_zero,
    output logic               rsp_err,

    output logic [DATA_W-1:0]  alu_src1,
    output logic [DATA_W-1:0]  alu_src2,
    output logic [FUNCT_W-1:0] alu_funct,
    output logic [SHAMT_W-1:0] alu_shamt,
    input  logic [DATA_W-1:0]  alu_result,
    input  logic               alu_zero,

    output logic               busy
);

    state_t             state_q, state_d;
    logic               prio_q;
    logic               owner_q;
    logic [DATA_W-1:0]  src1_q, src2_q;
    logic [FUNCT_W-1:0] funct_q;
    logic [SHAMT_W-1:0] shamt_q;
    logic [DATA_W-1:0]  res_q;
    logic               zero_q;
    logic               err_q;

    logic [1:0]         gnt;
    logic               accept;
    logic               rsp_done;
    logic               owner_rsp_ready;

    rr_arb2 u_rr_arb2 (
        .req  ({req1_valid, req0_valid}),
        .prio (prio_q),
        .gnt  (gnt)
    );

    assign owner_rsp_ready = owner_q ? rsp1_ready : rsp0_ready;

    // Next-state and handshake outputs.
    always_comb begin
        state_d    = state_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        accept     = 1'b0;
        rsp_done   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Gated by rst_n so ready stays low while reset is held, yet a
                // request can still be taken in the very first cycle after release.
                req0_ready = gnt[0] & rst_n;
                req1_ready = gnt[1] & rst_n;
                if (gnt != 2'b00) begin
                    accept  = 1'b1;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_d = ST_RESP;
            end
            ST_RESP: begin
                rsp0_valid = ~owner_q;
                rsp1_valid = owner_q;
                if (owner_rsp_ready) begin
                    rsp_done = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            prio_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            // The requester that was just served yields priority to the other.
            if (rsp_done) begin
                prio_q <= ~owner_q;
            end
        end
    end

    // Operand capture from the granted requester.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q <= 1'b0;
            src1_q  <= '0;
            src2_q  <= '0;
            funct_q <= '0;
            shamt_q <= '0;
        end else if (accept) begin
            owner_q <= gnt[1];
            src1_q  <= gnt[1] ? req1_src1  : req0_src1;
            src2_q  <= gnt[1] ? req1_src2  : req0_src2;
            funct_q <= gnt[1] ? req1_funct : req0_funct;
            shamt_q <= gnt[1] ? req1_shamt : req0_shamt;
        end
    end

    // Result capture at the edge that ends EXEC; unsupported codes report a
    // fixed zero result with the error flag instead of whatever the ALU produced.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q  <= '0;
            zero_q <= 1'b0;
            err_q  <= 1'b0;
        end else if (state_q == ST_EXEC) begin
            if (is_supported(FUNCT_CODE_W'(funct_q))) begin
                res_q  <= alu_result;
                zero_q <= alu_zero;
                err_q  <= 1'b0;
            end else begin
                res_q  <= '0;
                zero_q <= 1'b1;
                err_q  <= 1'b1;
            end
        end
    end

    assign alu_src1   = src1_q;
    assign alu_src2   = src2_q;
    assign alu_funct  = funct_q;
    assign alu_shamt  = shamt_q;

    assign rsp_result = res_q;
    assign rsp_zero   = zero_q;
    assign rsp_err    = err_q;

    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;

    localparam logic [5:0] F_ADDU = 6'b001001;
    localparam logic [5:0] F_SUBU = 6'b001010;
    localparam logic [5:0] F_AND  = 6'b010001;
    localparam logic [5:0] F_SLL  = 6'b100001;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  vld, rrdy, rdy, rv;
    logic [31:0] s1 [2];
    logic [31:0] s2 [2];
    logic [5:0]  fn [2];
    logic [4:0]  sh [2];
    logic [31:0] rsp_result, alu_src1, alu_src2, alu_result;
    logic        rsp_zero, rsp_err, alu_zero, busy;
    logic [5:0]  alu_funct;
    logic [4:0]  alu_shamt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // Reference ALU; unknown codes give junk the arbiter must discard.
    function automatic logic [31:0] alu_fn(input logic [5:0] f, input logic [31:0] a,
                                           input logic [31:0] b, input logic [4:0] s);
        case (f)
            F_ADDU:  return a + b;
            F_SUBU:  return a - b;
            F_AND:   return a & b;
            F_SLL:   return a << s;
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    function automatic bit known(input logic [5:0] f);
        return (f == F_ADDU) || (f == F_SUBU) || (f == F_AND) || (f == F_SLL);
    endfunction

    assign alu_result = alu_fn(alu_funct, alu_src1, alu_src2, alu_shamt);
    assign alu_zero   = (alu_result == 32'd0);

    alu_share_arbiter u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (vld[0]),
        .req0_ready (rdy[0]),
        .req0_src1  (s1[0]),
        .req0_src2  (s2[0]),
        .req0_funct (fn[0]),
        .req0_shamt (sh[0]),
        .req1_valid (vld[1]),
        .req1_ready (rdy[1]),
        .req1_src1  (s1[1]),
        .req1_src2  (s2[1]),
        .req1_funct (fn[1]),
        .req1_shamt (sh[1]),
        .rsp0_valid (rv[0]),
        .rsp0_ready (rrdy[0]),
        .rsp1_valid (rv[1]),
        .rsp1_ready (rrdy[1]),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero),
        .rsp_err    (rsp_err),
        .alu_src1   (alu_src1),
        .alu_src2   (alu_src2),
        .alu_funct  (alu_funct),
        .alu_shamt  (alu_shamt),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_op(input int n, input logic [5:0] f, input logic [31:0] a,
                            input logic [31:0] b, input logic [4:0] s);
        s1[n]  = a;
        s2[n]  = b;
        fn[n]  = f;
        sh[n]  = s;
        vld[n] = 1'b1;
    endtask

    // Call just before the negedge of the accepting IDLE cycle T; owner's rsp_ready
    // must be high. Checks grant in T, EXEC in T+1, response in T+2.
    task automatic op(input string tag, input int n, input logic [31:0] res,
                      input logic zero, input logic err, input bit drop);
        logic [1:0] one;
        one = (n == 1) ? 2'b10 : 2'b01;
        @(negedge clk);
        check($sformatf("%s.ready", tag), rdy, one);
        check($sformatf("%s.idle_busy", tag), busy, 1'b0);
        @(posedge clk);
        #1;
        if (drop) vld[n] = 1'b0;
        @(negedge clk);
        check($sformatf("%s.exec_busy", tag), busy, 1'b1);
        check($sformatf("%s.exec_rv", tag), {rdy, rv}, 4'b0000);
        @(negedge clk);
        check($sformatf("%s.rv", tag), rv, one);
        check($sformatf("%s.result", tag), rsp_result, res);
        check($sformatf("%s.zero", tag), rsp_zero, zero);
        check($sformatf("%s.err", tag), rsp_err, err);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0]  hsq, hsr, one;
        logic [31:0] exp_res;
        logic        exp_z, exp_e, exp_own;
        bit          pend;
        int          accepted, done, cyc;
        logic [5:0]  f;

        rst_n = 1'b0;
        rrdy  = 2'b00;
        for (int i = 0; i < 2; i++) begin
            s1[i] = '0; s2[i] = '0; fn[i] = '0; sh[i] = '0;
        end
        vld = 2'b11;
        repeat (2) @(negedge clk);
        // Reset state, with both requests valid.
        check("rst.ready", rdy, 2'b00);
        check("rst.rv", rv, 2'b00);
        check("rst.busy", busy, 1'b0);
        check("rst.rsp", {rsp_result, rsp_zero, rsp_err}, '0);
        check("rst.alu", {alu_src1, alu_src2, alu_funct, alu_shamt}, '0);
        vld = 2'b00;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 1: single addu on requester 0.
        drive_op(0, F_ADDU, 32'd5, 32'd7, 5'd0);
        rrdy = 2'b11;
        op("t1", 0, 32'd12, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("t1.after", {busy, rv, rdy}, 5'b0);

        // 2: both valid out of reset; prio must have reset to requester 0.
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        drive_op(0, F_SUBU, 32'd9, 32'd9, 5'd0);
        drive_op(1, F_SLL, 32'd1, 32'd0, 5'd4);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        op("t2a", 0, 32'd0, 1'b1, 1'b0, 1'b1);
        op("t2b", 1, 32'd16, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        vld = 2'b11;
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) op($sformatf("t2alt%0d", k), 0, 32'd0, 1'b1, 1'b0, 1'b0);
            else            op($sformatf("t2alt%0d", k), 1, 32'd16, 1'b0, 1'b0, 1'b0);
        end
        @(posedge clk);
        #1;
        vld = 2'b00;

        // 3: requester 1 response held off for 5 cycles; requester 0 waits.
        drive_op(1, F_AND, 32'h0F0F_00FF, 32'h0000_FFFF, 5'd0);
        rrdy = 2'b01;
        @(negedge clk);
        check("t3.ready", rdy, 2'b10);
        @(posedge clk);
        #1;
        vld[1] = 1'b0;
        drive_op(0, F_ADDU, 32'd3, 32'd4, 5'd0);
        @(negedge clk);
        check("t3.exec", {busy, rdy}, 3'b100);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("t3.hold%0d", i), {rv, rdy, rsp_err, rsp_zero}, 6'b100000);
            check($sformatf("t3.hold_res%0d", i), rsp_result, 32'h0000_00FF);
        end
        @(posedge clk);
        #1;
        rrdy = 2'b11;
        @(negedge clk);
        check("t3.release", {rv, rdy}, 4'b1000);
        op("t3b", 0, 32'd7, 1'b0, 1'b0, 1'b1);

        // 4: unsupported funct code.
        @(posedge clk);
        #1;
        drive_op(0, 6'b000000, 32'd5, 32'd7, 5'd3);
        op("t4", 0, 32'd0, 1'b1, 1'b1, 1'b1);

        // 5: reset in the middle of EXEC.
        @(posedge clk);
        #1;
        drive_op(0, F_ADDU, 32'd1, 32'd2, 5'd0);
        @(negedge clk);
        check("t5.ready", rdy, 2'b01);
        @(posedge clk);
        #1;
        vld[0] = 1'b0;
        @(negedge clk);
        check("t5.exec", busy, 1'b1);
        #1;
        rst_n = 1'b0;
        drive_op(1, F_SLL, 32'd1, 32'd0, 5'd4);
        #1;
        check("t5.rst_busy", busy, 1'b0);
        check("t5.rst_alu", alu_src1, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("t5.rst_hs%0d", i), {rv, rdy}, 4'b0000);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        op("t5b", 1, 32'd16, 1'b0, 1'b0, 1'b1);

        // 6: random traffic with a scoreboard.
        hsq = 2'b00; pend = 1'b0; accepted = 0; done = 0; cyc = 0;
        exp_res = '0; exp_z = 1'b0; exp_e = 1'b0; exp_own = 1'b0;
        while (done < 1000 && cyc < 30000) begin
            @(posedge clk);
            #1;
            cyc++;
            for (int n = 0; n < 2; n++) begin
                if (hsq[n]) vld[n] = 1'b0;
                if (vld[n]) begin
                    if ($urandom_range(7) == 0) vld[n] = 1'b0;
                end else if ($urandom_range(1) == 1) begin
                    case ($urandom_range(4))
                        0:       f = F_ADDU;
                        1:       f = F_SUBU;
                        2:       f = F_AND;
                        3:       f = F_SLL;
                        default: f = 6'($urandom_range(63));
                    endcase
                    drive_op(n, f, $urandom, ($urandom_range(3) == 0) ? s1[n] : $urandom,
                             5'($urandom_range(31)));
                end
            end
            rrdy = 2'($urandom_range(3));
            @(negedge clk);
            hsq = vld & rdy;
            hsr = rv & rrdy;
            one = exp_own ? 2'b10 : 2'b01;
            if (rv != 2'b00) check("t6.rv_owner", rv, pend ? one : 2'b00);
            if (hsr != 2'b00) begin
                check("t6.rsp_pending", pend, 1'b1);
                check("t6.result", rsp_result, exp_res);
                check("t6.zero_err", {rsp_zero, rsp_err}, {exp_z, exp_e});
                pend = 1'b0;
                done++;
            end
            if (hsq != 2'b00) begin
                check("t6.req_while_busy", {pend, hsq == 2'b11}, 2'b00);
                exp_own = hsq[1];
                if (known(fn[exp_own])) begin
                    exp_res = alu_fn(fn[exp_own], s1[exp_own], s2[exp_own], sh[exp_own]);
                    exp_z   = (exp_res == 32'd0);
                    exp_e   = 1'b0;
                end else begin
                    exp_res = 32'd0;
                    exp_z   = 1'b1;
                    exp_e   = 1'b1;
                end
                pend = 1'b1;
                accepted++;
            end
        end
        check("t6.done", done, 1000);
        check("t6.no_lost", accepted, done);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
